sparse_intersect_unit: RTL and testbench



---
 rtl/sparse_stream_pkg.sv | 43 ++++
 rtl/sparse_intersect_unit_out_reg.sv | 59 +++++
 rtl/sparse_intersect_unit.sv | 192 +++++++++++++++++++
 tb/tb_sparse_intersect_unit.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sparse_stream_pkg.sv
// ---------------------------------------------------------------------------
// sparse_stream_pkg
// Shared definitions for the sparse tile datapath stream blocks.
//   DATA_W      : stream word width (bit 16 = control flag, 15:0 = payload)
//   DONE_TOKEN  : end-of-tile control word
//   MAYBE_TOKEN : position word for a side that has no entry
//   ST_*        : joiner FSM state encodings
//   triple_t    : one output beat {coord, pos0, pos1}
//   is_data_word / is_done_token / is_stop_token : stream word classifiers
// ---------------------------------------------------------------------------
package sparse_stream_pkg;

  localparam int DATA_W = 17;

  localparam logic [DATA_W-1:0] DONE_TOKEN  = 17'h10100;
  localparam logic [DATA_W-1:0] MAYBE_TOKEN = 17'h10200;

  typedef logic [1:0] fsm_state_t;
  localparam fsm_state_t ST_IDLE = 2'd0;
  localparam fsm_state_t ST_RUN  = 2'd1;
  localparam fsm_state_t ST_DONE = 2'd2;

  typedef struct packed {
    logic [DATA_W-1:0] coord;
    logic [DATA_W-1:0] pos0;
    logic [DATA_W-1:0] pos1;
  } triple_t;

  function automatic logic is_data_word(input logic [DATA_W-1:0] w);
    return !w[DATA_W-1];
  endfunction

  function automatic logic is_done_token(input logic [DATA_W-1:0] w);
    return w == DONE_TOKEN;
  endfunction

  // Any flagged word other than DONE behaves as a stop token. Upstream only
  // produces payloads 0x00..0xFF here, so this is the Sn test.
  function automatic logic is_stop_token(input logic [DATA_W-1:0] w);
    return w[DATA_W-1] && (w != DONE_TOKEN);
  endfunction

endpackage

// File: rtl/sparse_intersect_unit_out_reg.sv
// ---------------------------------------------------------------------------
// sparse_out_reg
// Three-lane output register sharing a single valid bit. The beat is only
// consumed when all three lane readies are high at once.
//   clk, clr     : clock, synchronous clear (reset or flush)
//   en           : clock enable; low freezes the register
//   out_en       : masks the presented valid (tile idle / disabled / clear)
//   load, load_data : capture a new beat (only when free)
//   ready_0..2   : per-lane downstream readies
//   data, valid  : presented beat and shared valid
//   full         : register holds a beat (unmasked)
//   free         : a new beat may be loaded this cycle
//   fire         : the held beat is handshaking out this cycle
// ---------------------------------------------------------------------------
module sparse_out_reg
  import sparse_stream_pkg::*;
(
  input  logic    clk,
  input  logic    clr,
  input  logic    en,
  input  logic    out_en,
  input  logic    load,
  input  triple_t load_data,
  input  logic    ready_0,
  input  logic    ready_1,
  input  logic    ready_2,
  output triple_t data,
  output logic    valid,
  output logic    full,
  output logic    free,
  output logic    fire
);

  logic    full_q;
  triple_t data_q;

  assign valid = full_q & out_en;
  assign fire  = valid & ready_0 & ready_1 & ready_2;
  assign free  = !full_q | fire;
  assign full  = full_q;
  assign data  = data_q;

  // A load in the same cycle as a fire keeps the register full with the new
  // beat, so back-to-back beats flow at one per cycle.
  always_ff @(posedge clk) begin
    if (clr) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else if (en) begin
      if (load) begin
        full_q <= 1'b1;
        data_q <= load_data;
      end else if (fire) begin
        full_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/sparse_intersect_unit.sv
// ---------------------------------------------------------------------------
// sparse_intersect_unit
// Two-input sparse stream joiner: intersection (joiner_op=0) or union
// (joiner_op=1) of two coordinate streams, each with an aligned position
// stream. Output is {coord, pos0, pos1} with one shared valid.
//   clk, rst, flush, clk_en, tile_en, joiner_op : control
//   coord_in_i / pos_in_i (+valid/ready)        : input side i = 0,1
//   coord_out, pos_out_0, pos_out_1 (+valid/ready) : joined output
// Optional: define INTERSECT_PERF_CNT_EN to add cycle_count[63:0], which
// counts from the first input valid until the DONE beat leaves.
// ---------------------------------------------------------------------------
module sparse_intersect_unit
  import sparse_stream_pkg::*;
#(
  parameter logic [DATA_W-1:0] MAYBE_WORD = MAYBE_TOKEN
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clk_en,
  input  logic              flush,
  input  logic              tile_en,
  input  logic              joiner_op,
  input  logic [DATA_W-1:0] coord_in_0,
  input  logic              coord_in_0_valid,
  output logic              coord_in_0_ready,
  input  logic [DATA_W-1:0] coord_in_1,
  input  logic              coord_in_1_valid,
  output logic              coord_in_1_ready,
  input  logic [DATA_W-1:0] pos_in_0,
  input  logic              pos_in_0_valid,
  output logic              pos_in_0_ready,
  input  logic [DATA_W-1:0] pos_in_1,
  input  logic              pos_in_1_valid,
  output logic              pos_in_1_ready,
  output logic [DATA_W-1:0] coord_out,
  output logic              coord_out_valid,
  input  logic              coord_out_ready,
  output logic [DATA_W-1:0] pos_out_0,
  output logic              pos_out_0_valid,
  input  logic              pos_out_0_ready,
  output logic [DATA_W-1:0] pos_out_1,
  output logic              pos_out_1_valid,
  input  logic              pos_out_1_ready
`ifdef INTERSECT_PERF_CNT_EN
  ,
  output logic [63:0]       cycle_count
`endif
);

  logic       clr;
  logic       present_0, present_1;
  logic       decide;
  logic       pop_0, pop_1, emit, emit_done;
  triple_t    next_beat;
  triple_t    stage_data;
  logic       stage_valid, stage_full, stage_free, stage_fire;
  fsm_state_t state;

  logic d0, d1, done0, done1, stop0, stop1;

  assign clr       = rst | flush;
  assign present_0 = coord_in_0_valid & pos_in_0_valid;
  assign present_1 = coord_in_1_valid & pos_in_1_valid;

  assign d0    = is_data_word(coord_in_0);
  assign d1    = is_data_word(coord_in_1);
  assign done0 = is_done_token(coord_in_0);
  assign done1 = is_done_token(coord_in_1);
  assign stop0 = is_stop_token(coord_in_0) & !done0;
  assign stop1 = is_stop_token(coord_in_1) & !done1;

  // One decision per cycle, only with both heads present and room downstream.
  assign decide = (state == ST_RUN) & present_0 & present_1 & stage_free &
                  clk_en & tile_en & !clr;

  // Join decision on the two head words. In intersect mode an unmatched data
  // word is simply discarded; in union mode it is emitted with a MAYBE
  // word in the absent side's position lane.
  always_comb begin
    pop_0     = 1'b0;
    pop_1     = 1'b0;
    emit      = 1'b0;
    emit_done = 1'b0;
    next_beat = '{coord: coord_in_0, pos0: pos_in_0, pos1: pos_in_1};
    if (d0 && d1) begin
      if (coord_in_0[15:0] == coord_in_1[15:0]) begin
        pop_0 = 1'b1;
        pop_1 = 1'b1;
        emit  = 1'b1;
      end else if (coord_in_0[15:0] < coord_in_1[15:0]) begin
        pop_0     = 1'b1;
        emit      = joiner_op;
        next_beat = '{coord: coord_in_0, pos0: pos_in_0, pos1: MAYBE_WORD};
      end else begin
        pop_1     = 1'b1;
        emit      = joiner_op;
        next_beat = '{coord: coord_in_1, pos0: MAYBE_WORD, pos1: pos_in_1};
      end
    end else if (d0) begin
      pop_0     = 1'b1;
      emit      = joiner_op;
      next_beat = '{coord: coord_in_0, pos0: pos_in_0, pos1: MAYBE_WORD};
    end else if (d1) begin
      pop_1     = 1'b1;
      emit      = joiner_op;
      next_beat = '{coord: coord_in_1, pos0: MAYBE_WORD, pos1: pos_in_1};
    end else if (done0 && done1) begin
      pop_0     = 1'b1;
      pop_1     = 1'b1;
      emit      = 1'b1;
      emit_done = 1'b1;
      next_beat = '{coord: DONE_TOKEN, pos0: DONE_TOKEN, pos1: DONE_TOKEN};
    end else if (done0 && stop1) begin
      pop_1 = 1'b1;
    end else if (stop0 && done1) begin
      pop_0 = 1'b1;
    end else begin
      // Both stop tokens: side 0's level wins if they disagree.
      pop_0     = 1'b1;
      pop_1     = 1'b1;
      emit      = 1'b1;
      next_beat = '{coord: coord_in_0, pos0: coord_in_0, pos1: coord_in_0};
    end
  end

  assign coord_in_0_ready = decide & pop_0;
  assign pos_in_0_ready   = decide & pop_0;
  assign coord_in_1_ready = decide & pop_1;
  assign pos_in_1_ready   = decide & pop_1;

  sparse_out_reg u_out_reg (
    .clk       (clk),
    .clr       (clr),
    .en        (clk_en),
    .out_en    (tile_en & clk_en & !clr),
    .load      (decide & emit),
    .load_data (next_beat),
    .ready_0   (coord_out_ready),
    .ready_1   (pos_out_0_ready),
    .ready_2   (pos_out_1_ready),
    .data      (stage_data),
    .valid     (stage_valid),
    .full      (stage_full),
    .free      (stage_free),
    .fire      (stage_fire)
  );

  assign coord_out       = stage_data.coord;
  assign pos_out_0       = stage_data.pos0;
  assign pos_out_1       = stage_data.pos1;
  assign coord_out_valid = stage_valid;
  assign pos_out_0_valid = stage_valid;
  assign pos_out_1_valid = stage_valid;

  // Tile sequencing: the DONE state holds off new decisions until the DONE
  // beat has left the output register, so tiles never interleave.
  always_ff @(posedge clk) begin
    if (clr) begin
      state <= ST_IDLE;
    end else if (clk_en) begin
      case (state)
        ST_IDLE: if (tile_en) state <= ST_RUN;
        ST_RUN:  if (decide && emit_done) state <= ST_DONE;
        ST_DONE: if (!stage_full) state <= ST_RUN;
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef INTERSECT_PERF_CNT_EN
  logic perf_started, perf_stopped, any_in_valid;

  assign any_in_valid = coord_in_0_valid | coord_in_1_valid |
                        pos_in_0_valid | pos_in_1_valid;

  // Counting includes the first valid cycle and the DONE handshake cycle.
  always_ff @(posedge clk) begin
    if (clr) begin
      cycle_count  <= 64'd0;
      perf_started <= 1'b0;
      perf_stopped <= 1'b0;
    end else if (clk_en) begin
      if (any_in_valid) perf_started <= 1'b1;
      if ((perf_started || any_in_valid) && !perf_stopped)
        cycle_count <= cycle_count + 64'd1;
      if (stage_fire && (stage_data.coord == DONE_TOKEN))
        perf_stopped <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_sparse_intersect_unit.sv
module tb_sparse_intersect_unit;
  import sparse_stream_pkg::*;

  logic        clk;
  logic        rst, clk_en, flush, tile_en, joiner_op;
  logic [16:0] coord_in_0, coord_in_1, pos_in_0, pos_in_1;
  logic        coord_in_0_valid, coord_in_1_valid, pos_in_0_valid, pos_in_1_valid;
  logic        coord_in_0_ready, coord_in_1_ready, pos_in_0_ready, pos_in_1_ready;
  logic [16:0] coord_out, pos_out_0, pos_out_1;
  logic        coord_out_valid, pos_out_0_valid, pos_out_1_valid;
  logic        coord_out_ready, pos_out_0_ready, pos_out_1_ready;

  localparam logic [16:0] S0 = 17'h10000;
  localparam logic [16:0] S1 = 17'h10001;
  localparam logic [16:0] S2 = 17'h10002;
  localparam logic [16:0] DN = 17'h10100;
  localparam logic [16:0] MB = 17'h10200;

  typedef struct {
    logic [16:0] c;
    logic [16:0] p;
  } word_t;

  typedef struct {
    logic        op;
    logic [16:0] c0, p0, c1, p1;
    logic        pop0, pop1, emit;
    logic [16:0] ec, ep0, ep1;
  } vec_t;

  word_t   side_q0[$];
  word_t   side_q1[$];
  triple_t exp_q[$];
  vec_t    vecs[12];

  int   checks;
  int   errors;
  int   out_seen;
  logic sb_active;
  logic bp_mode;

  sparse_intersect_unit dut (
    .clk              (clk),
    .rst              (rst),
    .clk_en           (clk_en),
    .flush            (flush),
    .tile_en          (tile_en),
    .joiner_op        (joiner_op),
    .coord_in_0       (coord_in_0),
    .coord_in_0_valid (coord_in_0_valid),
    .coord_in_0_ready (coord_in_0_ready),
    .coord_in_1       (coord_in_1),
    .coord_in_1_valid (coord_in_1_valid),
    .coord_in_1_ready (coord_in_1_ready),
    .pos_in_0         (pos_in_0),
    .pos_in_0_valid   (pos_in_0_valid),
    .pos_in_0_ready   (pos_in_0_ready),
    .pos_in_1         (pos_in_1),
    .pos_in_1_valid   (pos_in_1_valid),
    .pos_in_1_ready   (pos_in_1_ready),
    .coord_out        (coord_out),
    .coord_out_valid  (coord_out_valid),
    .coord_out_ready  (coord_out_ready),
    .pos_out_0        (pos_out_0),
    .pos_out_0_valid  (pos_out_0_valid),
    .pos_out_0_ready  (pos_out_0_ready),
    .pos_out_1        (pos_out_1),
    .pos_out_1_valid  (pos_out_1_valid),
    .pos_out_1_ready  (pos_out_1_ready)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic triple_t mk(input logic [16:0] c, input logic [16:0] a, input logic [16:0] b);
    triple_t t;
    t.coord = c;
    t.pos0  = a;
    t.pos1  = b;
    return t;
  endfunction

  task automatic push0(input logic [16:0] c, input logic [16:0] p);
    word_t w;
    w.c = c;
    w.p = p;
    side_q0.push_back(w);
  endtask

  task automatic push1(input logic [16:0] c, input logic [16:0] p);
    word_t w;
    w.c = c;
    w.p = p;
    side_q1.push_back(w);
  endtask

  // One clock step: observe handshakes at the falling edge, then drive the
  // next stream heads just after the rising edge.
  task automatic tick();
    triple_t t;
    @(negedge clk);
    if (sb_active) begin
      checkOutput("valid_align",
                  {63'd0, (pos_out_0_valid == coord_out_valid) && (pos_out_1_valid == coord_out_valid)},
                  64'd1);
      if (coord_out_valid && coord_out_ready && pos_out_0_ready && pos_out_1_ready) begin
        out_seen++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_beat: got %h/%h/%h expected none", coord_out, pos_out_0, pos_out_1);
        end else begin
          t = exp_q.pop_front();
          checkOutput("beat", {13'd0, coord_out, pos_out_0, pos_out_1}, {13'd0, t});
        end
      end
      if (coord_in_0_valid && coord_in_0_ready && pos_in_0_ready && side_q0.size() > 0) void'(side_q0.pop_front());
      if (coord_in_1_valid && coord_in_1_ready && pos_in_1_ready && side_q1.size() > 0) void'(side_q1.pop_front());
    end
    @(posedge clk);
    #1;
    if (sb_active) begin
      coord_in_0_valid = side_q0.size() > 0;
      pos_in_0_valid   = side_q0.size() > 0;
      if (side_q0.size() > 0) begin
        coord_in_0 = side_q0[0].c;
        pos_in_0   = side_q0[0].p;
      end
      coord_in_1_valid = side_q1.size() > 0;
      pos_in_1_valid   = side_q1.size() > 0;
      if (side_q1.size() > 0) begin
        coord_in_1 = side_q1[0].c;
        pos_in_1   = side_q1[0].p;
      end
      pos_out_1_ready = bp_mode ? ~pos_out_1_ready : 1'b1;
    end
  endtask

  task automatic doReset();
    rst = 1'b1;
    sb_active = 1'b0;
    bp_mode = 1'b0;
    side_q0.delete();
    side_q1.delete();
    exp_q.delete();
    coord_in_0_valid = 1'b0;
    pos_in_0_valid   = 1'b0;
    coord_in_1_valid = 1'b0;
    pos_in_1_valid   = 1'b0;
    coord_out_ready  = 1'b1;
    pos_out_0_ready  = 1'b1;
    pos_out_1_ready  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    out_seen = 0;
  endtask

  task automatic runUntilDrained(input string name, input int budget);
    int n;
    n = 0;
    while ((exp_q.size() > 0 || side_q0.size() > 0 || side_q1.size() > 0) && n < budget) begin
      tick();
      n++;
    end
    checkOutput({name, "_completes"}, {63'd0, n < budget}, 64'd1);
    repeat (5) tick();
  endtask

  task automatic loadScenario1Inputs();
    push0(17'd1, 17'd0); push0(17'd3, 17'd1); push0(17'd5, 17'd2); push0(S0, S0); push0(DN, DN);
    push1(17'd3, 17'd0); push1(17'd4, 17'd1); push1(17'd5, 17'd2); push1(S0, S0); push1(DN, DN);
  endtask

  task automatic loadScenario1Intersect();
    loadScenario1Inputs();
    exp_q.push_back(mk(17'd3, 17'd1, 17'd0));
    exp_q.push_back(mk(17'd5, 17'd2, 17'd2));
    exp_q.push_back(mk(S0, S0, S0));
    exp_q.push_back(mk(DN, DN, DN));
  endtask

  // Drive one head pair, check which sides pop, then check the beat.
  task automatic applyStimulus(input int idx);
    vec_t v;
    v = vecs[idx];
    joiner_op = v.op;
    coord_in_0 = v.c0;  pos_in_0 = v.p0;
    coord_in_1 = v.c1;  pos_in_1 = v.p1;
    coord_in_0_valid = 1'b1;  pos_in_0_valid = 1'b1;
    coord_in_1_valid = 1'b1;  pos_in_1_valid = 1'b1;
    #2;
    checkOutput($sformatf("vec%0d_pop0", idx), {62'd0, coord_in_0_ready, pos_in_0_ready}, {62'd0, v.pop0, v.pop0});
    checkOutput($sformatf("vec%0d_pop1", idx), {62'd0, coord_in_1_ready, pos_in_1_ready}, {62'd0, v.pop1, v.pop1});
    @(posedge clk);
    #1;
    coord_in_0_valid = 1'b0;  pos_in_0_valid = 1'b0;
    coord_in_1_valid = 1'b0;  pos_in_1_valid = 1'b0;
    #2;
    checkOutput($sformatf("vec%0d_valid", idx), {61'd0, coord_out_valid, pos_out_0_valid, pos_out_1_valid},
                {61'd0, v.emit, v.emit, v.emit});
    if (v.emit)
      checkOutput($sformatf("vec%0d_beat", idx), {13'd0, coord_out, pos_out_0, pos_out_1}, {13'd0, v.ec, v.ep0, v.ep1});
    @(posedge clk);
    #1;
  endtask

  // Main test sequence.
  initial begin
    int n;
    checks = 0;
    errors = 0;
    out_seen = 0;
    sb_active = 1'b0;
    bp_mode = 1'b0;
    clk_en = 1'b1;
    flush = 1'b0;
    tile_en = 1'b1;
    joiner_op = 1'b0;
    coord_in_0 = 17'd0; coord_in_1 = 17'd0; pos_in_0 = 17'd0; pos_in_1 = 17'd0;

    vecs[0]  = '{1'b0, 17'd5, 17'd10, 17'd5, 17'd20, 1'b1, 1'b1, 1'b1, 17'd5, 17'd10, 17'd20};
    vecs[1]  = '{1'b0, 17'd3, 17'd1, 17'd7, 17'd2, 1'b1, 1'b0, 1'b0, 17'd0, 17'd0, 17'd0};
    vecs[2]  = '{1'b1, 17'd3, 17'd1, 17'd7, 17'd2, 1'b1, 1'b0, 1'b1, 17'd3, 17'd1, MB};
    vecs[3]  = '{1'b1, 17'd9, 17'd4, 17'd2, 17'd6, 1'b0, 1'b1, 1'b1, 17'd2, MB, 17'd6};
    vecs[4]  = '{1'b0, 17'd9, 17'd4, 17'd2, 17'd6, 1'b0, 1'b1, 1'b0, 17'd0, 17'd0, 17'd0};
    vecs[5]  = '{1'b0, 17'd4, 17'd1, S1, S1, 1'b1, 1'b0, 1'b0, 17'd0, 17'd0, 17'd0};
    vecs[6]  = '{1'b1, S1, S1, 17'd4, 17'd1, 1'b0, 1'b1, 1'b1, 17'd4, MB, 17'd1};
    vecs[7]  = '{1'b0, S2, S2, S1, S1, 1'b1, 1'b1, 1'b1, S2, S2, S2};
    vecs[8]  = '{1'b0, DN, DN, S0, S0, 1'b0, 1'b1, 1'b0, 17'd0, 17'd0, 17'd0};
    vecs[9]  = '{1'b1, DN, DN, 17'd6, 17'd3, 1'b0, 1'b1, 1'b1, 17'd6, MB, 17'd3};
    vecs[10] = '{1'b0, 17'h0FFFF, 17'd1, 17'h00001, 17'd2, 1'b0, 1'b1, 1'b0, 17'd0, 17'd0, 17'd0};
    vecs[11] = '{1'b0, DN, DN, DN, DN, 1'b1, 1'b1, 1'b1, DN, DN, DN};

    // Reset state, with both sides presenting data.
    rst = 1'b1;
    coord_out_ready = 1'b1; pos_out_0_ready = 1'b1; pos_out_1_ready = 1'b1;
    coord_in_0_valid = 1'b1; pos_in_0_valid = 1'b1;
    coord_in_1_valid = 1'b1; pos_in_1_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_valids", {61'd0, coord_out_valid, pos_out_0_valid, pos_out_1_valid}, 64'd0);
    checkOutput("reset_readies", {60'd0, coord_in_0_ready, pos_in_0_ready, coord_in_1_ready, pos_in_1_ready}, 64'd0);

    // Single-decision table.
    doReset();
    @(posedge clk);
    #1;
    for (int i = 0; i < 12; i++) applyStimulus(i);

    // Scenario 1: intersect.
    doReset();
    joiner_op = 1'b0;
    loadScenario1Intersect();
    sb_active = 1'b1;
    runUntilDrained("intersect", 200);

    // Scenario 2: union on the same streams.
    doReset();
    joiner_op = 1'b1;
    loadScenario1Inputs();
    exp_q.push_back(mk(17'd1, 17'd0, MB));
    exp_q.push_back(mk(17'd3, 17'd1, 17'd0));
    exp_q.push_back(mk(17'd4, MB, 17'd1));
    exp_q.push_back(mk(17'd5, 17'd2, 17'd2));
    exp_q.push_back(mk(S0, S0, S0));
    exp_q.push_back(mk(DN, DN, DN));
    sb_active = 1'b1;
    runUntilDrained("union", 200);

    // Scenario 3: empty side 0.
    doReset();
    joiner_op = 1'b0;
    push0(S0, S0); push0(DN, DN);
    push1(17'd2, 17'd0); push1(17'd7, 17'd1); push1(S0, S0); push1(DN, DN);
    exp_q.push_back(mk(S0, S0, S0));
    exp_q.push_back(mk(DN, DN, DN));
    sb_active = 1'b1;
    runUntilDrained("empty_side", 200);

    // Scenario 4: pos_out_1_ready toggling.
    doReset();
    joiner_op = 1'b0;
    loadScenario1Intersect();
    bp_mode = 1'b1;
    sb_active = 1'b1;
    runUntilDrained("backpressure", 300);
    bp_mode = 1'b0;

    // Scenario 5: reset after two beats, then a fresh tile.
    doReset();
    joiner_op = 1'b1;
    loadScenario1Inputs();
    exp_q.push_back(mk(17'd1, 17'd0, MB));
    exp_q.push_back(mk(17'd3, 17'd1, 17'd0));
    exp_q.push_back(mk(17'd4, MB, 17'd1));
    exp_q.push_back(mk(17'd5, 17'd2, 17'd2));
    exp_q.push_back(mk(S0, S0, S0));
    exp_q.push_back(mk(DN, DN, DN));
    sb_active = 1'b1;
    n = 0;
    while (out_seen < 2 && n < 200) begin
      tick();
      n++;
    end
    checkOutput("midreset_two_beats", {63'd0, out_seen >= 2}, 64'd1);
    rst = 1'b1;
    sb_active = 1'b0;
    side_q0.delete();
    side_q1.delete();
    exp_q.delete();
    #1;
    checkOutput("midreset_valids", {61'd0, coord_out_valid, pos_out_0_valid, pos_out_1_valid}, 64'd0);
    checkOutput("midreset_readies", {60'd0, coord_in_0_ready, pos_in_0_ready, coord_in_1_ready, pos_in_1_ready}, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    coord_in_0_valid = 1'b0; pos_in_0_valid = 1'b0;
    coord_in_1_valid = 1'b0; pos_in_1_valid = 1'b0;
    #1;
    checkOutput("postreset_empty", {61'd0, coord_out_valid, pos_out_0_valid, pos_out_1_valid}, 64'd0);
    joiner_op = 1'b0;
    loadScenario1Intersect();
    sb_active = 1'b1;
    runUntilDrained("fresh_tile", 200);

    // Scenario 6: two tiles back to back without reset.
    doReset();
    joiner_op = 1'b0;
    loadScenario1Intersect();
    push0(17'd8, 17'd5); push0(S0, S0); push0(DN, DN);
    push1(17'd8, 17'd6); push1(S0, S0); push1(DN, DN);
    exp_q.push_back(mk(17'd8, 17'd5, 17'd6));
    exp_q.push_back(mk(S0, S0, S0));
    exp_q.push_back(mk(DN, DN, DN));
    sb_active = 1'b1;
    runUntilDrained("two_tiles", 300);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
